lcd_ctrl_param: RTL
===================

Name: lcd_ctrl_param

Overview:
- Parametrised image-window controller for IMG_W x IMG_H images of DW-bit pixels.
- After reset it loads the image from IROM, then executes a stream of host commands on a 2x2 operation window.
- The processed image is streamed to IRAM on a WRITE command.
- Generalises the fixed 8x8 controller: configurable size and width, IRAM backpressure, pulsed done, RELOAD command, and the ability to keep running after a write.

Parameters:
IMG_W, 8, image width in pixels (power of 2, >=4)
IMG_H, 8, image height in pixels (power of 2, >=4)
DW, 8, pixel width in bits
AW, log2(IMG_W*IMG_H), pixel address width (derived, do not override)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd  in  4  command code
cmd_valid  in  1  command strobe
IROM_Q  in  DW  ROM read data, valid one cycle after IROM_rd/IROM_A
IROM_rd  out  1  ROM read enable
IROM_A  out  AW  ROM address (row-major, addr = y*IMG_W + x)
IRAM_valid  out  1  output pixel valid
IRAM_ready  in  1  sink accepts pixel when high with IRAM_valid
IRAM_D  out  DW  output pixel
IRAM_A  out  AW  output pixel address
busy  out  1  controller cannot accept a command
done  out  1  one-cycle pulse after the last IRAM beat of a WRITE

Behaviour:
- Reset (reset=0), asynchronous:
  - State=LOAD; busy=1; done=0; IROM_rd=0; IRAM_valid=0; IRAM_A=0; IRAM_D=0.
  - Window origin (x0,y0) = (IMG_W/2-1, IMG_H/2-1).
  - Pixel array contents are not reset.
- States: LOAD, IDLE, EXEC, WRITE.
- LOAD:
  - Cycles k=0..N-1 after reset release (N=IMG_W*IMG_H): IROM_rd=1, IROM_A=k.
  - IROM_Q is captured into pixel[k] at cycle k+1.
  - IROM_rd=0 from cycle N; last capture at cycle N; busy=0 and state=IDLE from cycle N+1.
- Command acceptance: a command is accepted on a rising edge with cmd_valid=1 and busy=0. cmd_valid while busy=1 is ignored, not queued.
- Non-WRITE commands: on acceptance, busy=1 for exactly one cycle (EXEC), then busy=0; the array and window are updated at the end of EXEC.
- Window pixels: A=(x0,y0), B=(x0+1,y0), C=(x0,y0+1), D=(x0+1,y0+1).
- Command codes:
  - 0 WRITE.
  - 1 shift up: y0-1, saturating at 0.
  - 2 shift down: y0+1, saturating at IMG_H-2.
  - 3 shift left: x0-1, saturating at 0.
  - 4 shift right: x0+1, saturating at IMG_W-2.
  - 5 MAX: A,B,C,D all set to max(A,B,C,D).
  - 6 MIN: A,B,C,D all set to min(A,B,C,D).
  - 7 AVG: A,B,C,D all set to floor((A+B+C+D)/4); sum carried in DW+2 bits, no overflow.
  - 8 rotate CCW: A<=B, B<=D, D<=C, C<=A.
  - 9 rotate CW: A<=C, C<=D, D<=B, B<=A.
  - 10 mirror X: swap A<->C, B<->D.
  - 11 mirror Y: swap A<->B, C<->D.
  - 12 RELOAD: enters LOAD as after reset (busy stays high, window origin re-centred).
  - 13-15: no-op with the one-cycle busy.
- WRITE:
  - busy=1. Addresses 0..N-1 stream in order with IRAM_valid=1, IRAM_A=addr, IRAM_D=pixel[addr].
  - A beat completes when IRAM_valid&&IRAM_ready. While IRAM_ready=0, IRAM_A and IRAM_D hold stable.
  - First beat is valid the cycle after acceptance. With IRAM_ready held high, a WRITE occupies N cycles of IRAM_valid.
  - On the cycle after the final beat completes: IRAM_valid=0, done=1 for one cycle, busy=0, state=IDLE.
  - Window origin is unchanged by WRITE. Further commands are allowed after a WRITE.
- Reset asserted mid-LOAD, EXEC or WRITE aborts immediately. Outputs take reset values; the load restarts on release.

Test Plan:
- ROM[k]=k (8x8), IRAM_ready=1, WRITE after load -> busy falls at cycle 65; IRAM_A/IRAM_D = k/k for 64 consecutive cycles; done pulses exactly once; busy=0 the same cycle.
- From reset, 5x shift up then 5x shift left, then MAX -> origin saturates at (0,0); pixels 0,1,8,9 all = 9.
- Origin (3,3), pixels 27=10, 28=20, 35=30, 36=41, AVG -> all four = 25. Repeat with MIN -> 10. Repeat with MAX -> 41.
- Same quad A=1, B=2, C=3, D=4 -> CW gives A=3, B=1, C=4, D=2. CCW then gives back the original. Mirror X gives A=3, B=4, C=1, D=2.
- WRITE with IRAM_ready toggling 1,0,0,1 -> IRAM_A/IRAM_D stay stable while ready is low; every address is accepted exactly once; done pulses once after address 63.
- IMG_W=16, IMG_H=4, DW=10, ROM[k]=1023-k:
  - Shift down 3x gives y0=2 (saturated).
  - AVG on 1023-valued pixels gives no overflow.
  - RELOAD restores the ROM values.
  - cmd_valid asserted while busy is ignored.
  - Reset mid-WRITE drops IRAM_valid immediately.

Source files
------------

// File: rtl/lcd_ctrl_param_if.sv
// Command / IROM / IRAM bundle for lcd_ctrl_param.
//   master : host side   (drives cmd, cmd_valid, IROM_Q, IRAM_ready)
//   slave  : controller  (drives IROM_rd/IROM_A, IRAM_valid/IRAM_A/IRAM_D, busy, done)
interface lcd_ctrl_param_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] IROM_Q;
  logic          IROM_rd;
  logic [AW-1:0] IROM_A;
  logic          IRAM_valid;
  logic          IRAM_ready;
  logic [DW-1:0] IRAM_D;
  logic [AW-1:0] IRAM_A;
  logic          busy;
  logic          done;

  modport master (
    output cmd, cmd_valid, IROM_Q, IRAM_ready,
    input  IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );

  modport slave (
    input  cmd, cmd_valid, IROM_Q, IRAM_ready,
    output IROM_rd, IROM_A, IRAM_valid, IRAM_D, IRAM_A, busy, done
  );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Image-window controller: loads an IMG_W x IMG_H image of DW-bit pixels from
// IROM, runs host commands on a 2x2 window, streams the image to IRAM on WRITE.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : lcd_ctrl_param_if.slave (cmd/cmd_valid, IROM_*, IRAM_*, busy, done)
module lcd_ctrl_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int DW    = 8
) (
  input logic             clk,
  input logic             reset,
  lcd_ctrl_param_if.slave bus
);
  localparam int N  = IMG_W * IMG_H;
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [XW-1:0] X_CTR = XW'(IMG_W/2 - 1);
  localparam logic [YW-1:0] Y_CTR = YW'(IMG_H/2 - 1);
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 2);
  localparam logic [AW-1:0] A_LAST = AW'(N - 1);
  localparam logic [AW:0]   LD_END = (AW+1)'(N);

  typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   ld_cnt_q;            // ROM reads issued so far
  logic          rd_q;
  logic [AW-1:0] rom_a_q;
  logic          cap_vld_q;           // ROM data for cap_a_q is on IROM_Q now
  logic [AW-1:0] cap_a_q;
  logic [XW-1:0] x0_q;
  logic [YW-1:0] y0_q;
  logic [3:0]    op_q;
  logic          wv_q;
  logic [AW-1:0] wa_q;
  logic [DW-1:0] wd_q;
  logic          done_q;
  logic [DW-1:0] pix_q [N];

  // Power-of-2 width makes row-major y*IMG_W+x a plain concatenation.
  // x0 <= IMG_W-2 and y0 <= IMG_H-2, so the +1 never wraps.
  logic [AW-1:0] ia, ib, ic, id;
  assign ia = {y0_q, x0_q};
  assign ib = {y0_q, x0_q + XW'(1)};
  assign ic = {y0_q + YW'(1), x0_q};
  assign id = {y0_q + YW'(1), x0_q + XW'(1)};

  logic [DW-1:0] pa, pb, pc, pd;
  assign pa = pix_q[ia];
  assign pb = pix_q[ib];
  assign pc = pix_q[ic];
  assign pd = pix_q[id];

  logic [DW-1:0] mx_ab, mx_cd, mx, mn_ab, mn_cd, mn;
  logic [DW+1:0] sum;
  assign mx_ab = (pa > pb) ? pa : pb;
  assign mx_cd = (pc > pd) ? pc : pd;
  assign mx    = (mx_ab > mx_cd) ? mx_ab : mx_cd;
  assign mn_ab = (pa < pb) ? pa : pb;
  assign mn_cd = (pc < pd) ? pc : pd;
  assign mn    = (mn_ab < mn_cd) ? mn_ab : mn_cd;
  assign sum   = {2'b00, pa} + {2'b00, pb} + {2'b00, pc} + {2'b00, pd};

  logic beat, last_beat;
  assign beat      = wv_q && bus.IRAM_ready;
  assign last_beat = beat && (wa_q == A_LAST);

  logic [AW-1:0] wa_nxt;
  assign wa_nxt = wa_q + AW'(1);

  // Window rewrite for the array-modifying commands (only during EXEC)
  logic [DW-1:0] na, nb, nc, nd;
  logic          win_we;
  always_comb begin
    na = pa; nb = pb; nc = pc; nd = pd;
    win_we = 1'b0;
    if (state_q == S_EXEC) begin
      case (op_q)
        4'd5:  begin na = mx; nb = mx; nc = mx; nd = mx; win_we = 1'b1; end
        4'd6:  begin na = mn; nb = mn; nc = mn; nd = mn; win_we = 1'b1; end
        4'd7:  begin
          na = sum[DW+1:2]; nb = sum[DW+1:2];
          nc = sum[DW+1:2]; nd = sum[DW+1:2];
          win_we = 1'b1;
        end
        4'd8:  begin na = pb; nb = pd; nd = pc; nc = pa; win_we = 1'b1; end
        4'd9:  begin na = pc; nc = pd; nd = pb; nb = pa; win_we = 1'b1; end
        4'd10: begin na = pc; nc = pa; nb = pd; nd = pb; win_we = 1'b1; end
        4'd11: begin na = pb; nb = pa; nc = pd; nd = pc; win_we = 1'b1; end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  if (cap_vld_q && cap_a_q == A_LAST) state_d = S_IDLE;
      S_IDLE:  if (bus.cmd_valid) state_d = (bus.cmd == 4'd0) ? S_WRITE : S_EXEC;
      S_EXEC:  state_d = (op_q == 4'd12) ? S_LOAD : S_IDLE;
      S_WRITE: if (last_beat) state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_LOAD;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt_q  <= '0;
      rd_q      <= 1'b0;
      rom_a_q   <= '0;
      cap_vld_q <= 1'b0;
      cap_a_q   <= '0;
      x0_q      <= X_CTR;
      y0_q      <= Y_CTR;
      op_q      <= '0;
      wv_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cap_vld_q <= rd_q;
      cap_a_q   <= rom_a_q;
      case (state_q)
        S_LOAD: begin
          if (ld_cnt_q != LD_END) begin
            rd_q     <= 1'b1;
            rom_a_q  <= ld_cnt_q[AW-1:0];
            ld_cnt_q <= ld_cnt_q + (AW+1)'(1);
          end else begin
            rd_q <= 1'b0;
          end
        end
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q <= bus.cmd;
            if (bus.cmd == 4'd0) begin
              wv_q <= 1'b1;
              wa_q <= '0;
              wd_q <= pix_q[0];
            end
          end
        end
        S_EXEC: begin
          case (op_q)
            4'd1: if (y0_q != '0)    y0_q <= y0_q - YW'(1);
            4'd2: if (y0_q != Y_MAX) y0_q <= y0_q + YW'(1);
            4'd3: if (x0_q != '0)    x0_q <= x0_q - XW'(1);
            4'd4: if (x0_q != X_MAX) x0_q <= x0_q + XW'(1);
            4'd12: begin
              ld_cnt_q <= '0;
              x0_q     <= X_CTR;
              y0_q     <= Y_CTR;
            end
            default: ;
          endcase
        end
        S_WRITE: begin
          if (last_beat) begin
            wv_q   <= 1'b0;
            done_q <= 1'b1;
          end else if (beat) begin
            wa_q <= wa_nxt;
            wd_q <= pix_q[wa_nxt];
          end
        end
        default: ;
      endcase
    end
  end

  // Pixel store is deliberately not reset; the load refills it.
  always_ff @(posedge clk) begin
    if (cap_vld_q) begin
      pix_q[cap_a_q] <= bus.IROM_Q;
    end else if (win_we) begin
      pix_q[ia] <= na;
      pix_q[ib] <= nb;
      pix_q[ic] <= nc;
      pix_q[id] <= nd;
    end
  end

  assign bus.IROM_rd    = rd_q;
  assign bus.IROM_A     = rom_a_q;
  assign bus.IRAM_valid = wv_q;
  assign bus.IRAM_A     = wa_q;
  assign bus.IRAM_D     = wd_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
endmodule
